csr_arbiter: RTL and testbench



---
 rtl/csr_arbiter_pkg.sv | 29 ++
 rtl/csr_arbiter_pick.sv | 47 ++++
 rtl/csr_arbiter.sv | 122 ++++++++++++
 tb/tb_csr_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/csr_arbiter_pkg.sv
// Shared definitions for the CSR arbiter: FSM state encoding, default bus widths
// and the helper that sizes the grant index.
package csr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_READ  = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam int CSR_AW_DEF = 14;
  localparam int CSR_DW_DEF = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // A single requester still needs a one-bit index to keep vectors legal.
  function automatic int gnt_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/csr_arbiter_pick.sv
// Combinational requester picker: round-robin above the last grant with CSR_ARB_RR_EN,
// lowest requesting index otherwise. Zero latency; valid low when nobody requests.
module csr_arbiter_pick
  import csr_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = gnt_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [IW-1:0]   gnt_o,
  output logic            vld_o
);

`ifdef CSR_ARB_RR_EN
  logic [IW-1:0] idx;

  // Walk from farthest to nearest so the nearest index above last_i wins.
  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(last_i) + k) % NREQ);
      if (req_i[idx]) begin
        gnt_o = idx;
        vld_o = 1'b1;
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last_i;

  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_o = IW'(i);
        vld_o = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/csr_arbiter.sv
// Shares one CSR slave among NREQ masters, one single-beat transaction at a time; write acks in T+2,
// read data/ack in T+3, requests wait at their REQ level. CSR_ARB_RR_EN selects round-robin over fixed priority.
module csr_arbiter
  import csr_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = CSR_AW_DEF,
  parameter int DW   = CSR_DW_DEF
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [NREQ-1:0]    M_REQ,
  input  logic [NREQ-1:0]    M_WE,
  input  logic [NREQ*AW-1:0] M_A,
  input  logic [NREQ*DW-1:0] M_DW,
  output logic [NREQ-1:0]    M_ACK,
  output logic [DW-1:0]      M_DR,
  output logic [AW-1:0]      CSR_A,
  output logic               CSR_WE,
  output logic [DW-1:0]      CSR_DW,
  input  logic [DW-1:0]      CSR_DR
);

  localparam int IW = gnt_w(NREQ);

  state_e        state_q;
  logic [IW-1:0] gnt_q;
  logic [IW-1:0] last_ptr;
  logic [IW-1:0] pick_gnt;
  logic          pick_vld;

  logic [NREQ-1:0] m_ack_q;
  logic [DW-1:0]   m_dr_q;
  logic [AW-1:0]   csr_a_q;
  logic            csr_we_q;
  logic [DW-1:0]   csr_dw_q;

  logic [AW-1:0] sel_a_d;
  logic          sel_we_d;
  logic [DW-1:0] sel_dw_d;

`ifdef CSR_ARB_RR_EN
  logic [IW-1:0] ptr_q;
  assign last_ptr = ptr_q;
`else
  assign last_ptr = '0;
`endif

  csr_arbiter_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i  (M_REQ),
    .last_i (last_ptr),
    .gnt_o  (pick_gnt),
    .vld_o  (pick_vld)
  );

  assign sel_a_d  = M_A[int'(pick_gnt) * AW +: AW];
  assign sel_we_d = M_WE[pick_gnt];
  assign sel_dw_d = sel_we_d ? M_DW[int'(pick_gnt) * DW +: DW] : '0;

  // CSR_WE doubles as the latched transaction type while in ISSUE.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      m_ack_q  <= '0;
      m_dr_q   <= '0;
      csr_a_q  <= '0;
      csr_we_q <= 1'b0;
      csr_dw_q <= '0;
`ifdef CSR_ARB_RR_EN
      ptr_q    <= IW'(NREQ - 1);
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            gnt_q    <= pick_gnt;
            csr_a_q  <= sel_a_d;
            csr_we_q <= sel_we_d;
            csr_dw_q <= sel_dw_d;
`ifdef CSR_ARB_RR_EN
            ptr_q    <= pick_gnt;
`endif
            state_q  <= ST_ISSUE;
          end else begin
            csr_a_q  <= '0;
            csr_we_q <= 1'b0;
            csr_dw_q <= '0;
          end
        end
        ST_ISSUE: begin
          csr_we_q <= 1'b0;
          csr_dw_q <= '0;
          if (csr_we_q) begin
            m_ack_q[gnt_q] <= 1'b1;
            state_q        <= ST_DONE;
          end else begin
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          m_dr_q         <= CSR_DR;
          m_ack_q[gnt_q] <= 1'b1;
          state_q        <= ST_DONE;
        end
        ST_DONE: begin
          m_ack_q <= '0;
          csr_a_q <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign M_ACK  = m_ack_q;
  assign M_DR   = m_dr_q;
  assign CSR_A  = csr_a_q;
  assign CSR_WE = csr_we_q;
  assign CSR_DW = csr_dw_q;

endmodule

// File: tb/tb_csr_arbiter.sv
// Bench for csr_arbiter: directed scenarios then random traffic, every cycle compared
// against a transaction-schedule reference model that follows the documented timing.
`timescale 1ns/1ps
module tb_csr_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 14;
  localparam int DW   = 32;
  localparam int MAXC = 4096;
`ifdef CSR_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic               PCLK = 1'b0;
  logic               PRESET;
  logic [NREQ-1:0]    M_REQ;
  logic [NREQ-1:0]    M_WE;
  logic [NREQ*AW-1:0] M_A;
  logic [NREQ*DW-1:0] M_DW;
  logic [NREQ-1:0]    M_ACK;
  logic [DW-1:0]      M_DR;
  logic [AW-1:0]      CSR_A;
  logic               CSR_WE;
  logic [DW-1:0]      CSR_DW;
  logic [DW-1:0]      CSR_DR;

  csr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .M_REQ  (M_REQ),
    .M_WE   (M_WE),
    .M_A    (M_A),
    .M_DW   (M_DW),
    .M_ACK  (M_ACK),
    .M_DR   (M_DR),
    .CSR_A  (CSR_A),
    .CSR_WE (CSR_WE),
    .CSR_DW (CSR_DW),
    .CSR_DR (CSR_DR)
  );

  always #5 PCLK = ~PCLK;

  // CSR slave contents: one fixed word at 0x1234, an address-derived pattern elsewhere.
  function automatic logic [DW-1:0] dr_fn(input logic [AW-1:0] a);
    if (a == 14'h1234) return 32'hCAFE0001;
    return {2'b10, a, ~a, 2'b01};
  endfunction

  // Registered slave: data for the address seen on one edge appears after it.
  always @(posedge PCLK) CSR_DR <= dr_fn(CSR_A);

  // Expected outputs per cycle; all-zero unless a transaction schedules something.
  logic [NREQ-1:0] e_ack [MAXC];
  logic            e_we  [MAXC];
  logic [AW-1:0]   e_a   [MAXC];
  logic [DW-1:0]   e_dw  [MAXC];
  logic            e_rd  [MAXC];
  logic [DW-1:0]   e_rdv [MAXC];
  logic            e_rst [MAXC];

  int            n;
  int            free_at;
  int            last;
  logic [DW-1:0] dr_cur;
  bit            rst_req;
  int            total;
  int            passed;

  bit            pend [NREQ];
  logic          p_we [NREQ];
  logic [AW-1:0] p_a  [NREQ];
  logic [DW-1:0] p_dw [NREQ];

  function automatic int pick(input logic [NREQ-1:0] req, input int lst);
    for (int k = 1; k <= NREQ; k++) begin
      if (req[(lst + k) % NREQ]) return (lst + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, n, obs, expv);
  endtask

  task automatic req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] dw);
    if (pend[i]) return;
    if (n >= 1 && e_ack[n-1][i]) return;
    pend[i] = 1'b1;
    p_we[i] = we;
    p_a[i]  = a;
    p_dw[i] = dw;
  endtask

  // Apply the model for the current cycle, then drive the inputs for it.
  task automatic commit();
    logic [NREQ-1:0] rq;
    int g;
    int lst;
    rq = '0;
    for (int i = 0; i < NREQ; i++) rq[i] = pend[i];
    if (rst_req) begin
      for (int k = n + 1; k <= n + 4; k++) begin
        e_ack[k] = '0; e_we[k] = 1'b0; e_a[k] = '0; e_dw[k] = '0; e_rd[k] = 1'b0;
      end
      e_rst[n+1] = 1'b1;
      free_at = n + 1;
      last = NREQ - 1;
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    end else if (free_at <= n && rq != '0) begin
      lst = RR_MODE ? last : NREQ - 1;
      g = pick(rq, lst);
      last = g;
      e_we[n+1] = p_we[g];
      e_a[n+1]  = p_a[g];
      e_dw[n+1] = p_we[g] ? p_dw[g] : '0;
      e_a[n+2]  = p_a[g];
      if (p_we[g]) begin
        e_ack[n+2] = NREQ'(1) << g;
        free_at = n + 3;
      end else begin
        e_a[n+3]   = p_a[g];
        e_ack[n+3] = NREQ'(1) << g;
        e_rd[n+3]  = 1'b1;
        e_rdv[n+3] = dr_fn(p_a[g]);
        free_at = n + 4;
      end
    end
    PRESET = rst_req;
    for (int i = 0; i < NREQ; i++) begin
      M_REQ[i]           = pend[i];
      M_WE[i]            = p_we[i];
      M_A[i*AW +: AW]    = p_a[i];
      M_DW[i*DW +: DW]   = p_dw[i];
    end
  endtask

  task automatic sample();
    @(posedge PCLK);
    #1;
    n++;
    if (e_rst[n]) dr_cur = '0;
    else if (e_rd[n]) dr_cur = e_rdv[n];
    chk("M_ACK",  64'(M_ACK),  64'(e_ack[n]));
    chk("CSR_WE", 64'(CSR_WE), 64'(e_we[n]));
    chk("CSR_A",  64'(CSR_A),  64'(e_a[n]));
    chk("CSR_DW", 64'(CSR_DW), 64'(e_dw[n]));
    chk("M_DR",   64'(M_DR),   64'(dr_cur));
    for (int i = 0; i < NREQ; i++) begin
      if (e_ack[n-1][i]) pend[i] = 1'b0;
    end
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      commit();
      sample();
    end
  endtask

  initial begin
    for (int k = 0; k < MAXC; k++) begin
      e_ack[k] = '0; e_we[k] = 1'b0; e_a[k] = '0; e_dw[k] = '0;
      e_rd[k] = 1'b0; e_rdv[k] = '0; e_rst[k] = 1'b0;
    end
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; p_we[i] = 1'b0; p_a[i] = '0; p_dw[i] = '0;
    end
    n = 0; free_at = 0; last = NREQ - 1; dr_cur = '0;
    total = 0; passed = 0;

    // Reset for two cycles; reset values are checked on the way out.
    rst_req = 1'b1;
    run(2);
    rst_req = 1'b0;

    // Single write from port 0.
    req(0, 1'b1, 14'h0005, 32'hDEADBEEF);
    run(6);

    // Single read from port 1.
    req(1, 1'b0, 14'h1234, 32'h0);
    run(6);

    // Both ports request together and re-request as soon as allowed.
    for (int c = 0; c < 32; c++) begin
      req(0, 1'($urandom_range(0, 1)), AW'($urandom), 32'($urandom));
      req(1, 1'($urandom_range(0, 1)), AW'($urandom), 32'($urandom));
      run(1);
    end
    run(6);

    // Port 1 arrives during the ISSUE cycle of a port 0 read.
    req(0, 1'b0, 14'h1234, 32'h0);
    run(1);
    req(1, 1'b1, 14'h0777, 32'h1234_5678);
    run(10);

    // Reset lands while a port 0 read is in READ; nothing acks, then normal service resumes.
    req(0, 1'b0, 14'h0100, 32'h0);
    run(2);
    rst_req = 1'b1;
    run(1);
    rst_req = 1'b0;
    req(0, 1'b1, 14'h0042, 32'h0BAD_F00D);
    req(1, 1'b0, 14'h1234, 32'h0);
    run(12);

    // Random traffic with occasional resets.
    for (int c = 0; c < 2000; c++) begin
      rst_req = ($urandom_range(0, 249) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 2) == 0)
          req(i, 1'($urandom_range(0, 1)), AW'($urandom), 32'($urandom));
      end
      run(1);
    end
    rst_req = 1'b0;
    run(8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
